// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, sync strobes, data-enable and frame index.
// All outputs are registered from the same counter position, so they stay cycle-aligned.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        H_POL    = 1'b1,
  parameter logic        V_POL    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
  localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic [15:0] frame_idx;

  logic de_c;
  logic hs_act_c;
  logic vs_act_c;
  logic h_wrap_c;
  logic v_wrap_c;

  // Decode of the current counter position
  always_comb begin
    de_c     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_act_c = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_act_c = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    h_wrap_c = (h_cnt == H_LAST);
    v_wrap_c = (v_cnt == V_LAST);
  end

  // Output registers load the decode, then counters advance; strobes drop when idle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      frame_idx     <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_h_sync      <= ~H_POL;
      o_v_sync      <= ~V_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else if (i_ce) begin
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_de          <= de_c;
      o_h_sync      <= hs_act_c ? H_POL : ~H_POL;
      o_v_sync      <= vs_act_c ? V_POL : ~V_POL;
      o_line_start  <= (h_cnt == 16'd0);
      o_frame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
      o_frame_cnt   <= frame_idx;
      if (h_wrap_c) begin
        h_cnt <= '0;
        if (v_wrap_c) begin
          v_cnt     <= '0;
          frame_idx <= frame_idx + 16'd1;
        end else begin
          v_cnt <= v_cnt + 16'd1;
        end
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small config, small config with inverted polarity, and default 720p,
// all driven from one reset/enable and checked against a reference raster model via a scoreboard.
module tb_video_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  typedef exp_t [2:0] trio_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic [15:0] ox  [3];
  logic [15:0] oy  [3];
  logic [15:0] ofc [3];
  logic        ohs [3];
  logic        ovs [3];
  logic        ode [3];
  logic        ols [3];
  logic        ofs [3];

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference configuration per instance: 0 small, 1 small inverted polarity, 2 default 720p
  int unsigned HA [3] = '{8, 8, 1280};
  int unsigned HF [3] = '{2, 2, 110};
  int unsigned HS [3] = '{2, 2, 40};
  int unsigned HB [3] = '{2, 2, 220};
  int unsigned VA [3] = '{4, 4, 720};
  int unsigned VF [3] = '{1, 1, 5};
  int unsigned VS [3] = '{1, 1, 5};
  int unsigned VB [3] = '{1, 1, 20};
  bit          HP [3] = '{1'b1, 1'b0, 1'b1};
  bit          VP [3] = '{1'b1, 1'b0, 1'b1};

  int unsigned mh [3];
  int unsigned mv [3];
  int unsigned mf [3];
  exp_t        last [3];
  trio_t       sb [$];

  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .o_x(ox[0]), .o_y(oy[0]), .o_h_sync(ohs[0]), .o_v_sync(ovs[0]), .o_de(ode[0]),
    .o_line_start(ols[0]), .o_frame_start(ofs[0]), .o_frame_cnt(ofc[0]));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .o_x(ox[1]), .o_y(oy[1]), .o_h_sync(ohs[1]), .o_v_sync(ovs[1]), .o_de(ode[1]),
    .o_line_start(ols[1]), .o_frame_start(ofs[1]), .o_frame_cnt(ofc[1]));

  video_timing_gen dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .o_x(ox[2]), .o_y(oy[2]), .o_h_sync(ohs[2]), .o_v_sync(ovs[2]), .o_de(ode[2]),
    .o_line_start(ols[2]), .o_frame_start(ofs[2]), .o_frame_cnt(ofc[2]));

  function automatic exp_t model_decode(input int k);
    exp_t e;
    bit hs_act, vs_act;
    hs_act = (mh[k] >= HA[k] + HF[k]) && (mh[k] < HA[k] + HF[k] + HS[k]);
    vs_act = (mv[k] >= VA[k] + VF[k]) && (mv[k] < VA[k] + VF[k] + VS[k]);
    e.x  = 16'(mh[k]);
    e.y  = 16'(mv[k]);
    e.de = (mh[k] < HA[k]) && (mv[k] < VA[k]);
    e.hs = hs_act ? HP[k] : !HP[k];
    e.vs = vs_act ? VP[k] : !VP[k];
    e.ls = (mh[k] == 0);
    e.fs = (mh[k] == 0) && (mv[k] == 0);
    e.fc = 16'(mf[k]);
    return e;
  endfunction

  task automatic model_advance(input int k);
    mh[k] = mh[k] + 1;
    if (mh[k] == HA[k] + HF[k] + HS[k] + HB[k]) begin
      mh[k] = 0;
      mv[k] = mv[k] + 1;
      if (mv[k] == VA[k] + VF[k] + VS[k] + VB[k]) begin
        mv[k] = 0;
        mf[k] = (mf[k] + 1) & 32'hffff;
      end
    end
  endtask

  function automatic exp_t observe(input int k);
    exp_t o;
    o.x = ox[k]; o.y = oy[k]; o.hs = ohs[k]; o.vs = ovs[k]; o.de = ode[k];
    o.ls = ols[k]; o.fs = ofs[k]; o.fc = ofc[k];
    return o;
  endfunction

  // Drive one clock: push model expectations, then pop and compare after the edge
  task automatic step(input logic rst_v, input logic ce_v);
    trio_t t;
    exp_t  o;
    rst_n = rst_v;
    ce    = ce_v;
    for (int k = 0; k < 3; k++) begin
      if (!rst_v) begin
        mh[k] = 0; mv[k] = 0; mf[k] = 0;
        t[k] = '{x: 16'd0, y: 16'd0, hs: !HP[k], vs: !VP[k], de: 1'b0,
                 ls: 1'b0, fs: 1'b0, fc: 16'd0};
      end else if (ce_v) begin
        t[k] = model_decode(k);
        model_advance(k);
      end else begin
        t[k] = last[k];
        t[k].ls = 1'b0;
        t[k].fs = 1'b0;
      end
      last[k] = t[k];
    end
    sb.push_back(t);
    @(posedge clk);
    #1;
    t = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      o = observe(k);
      checks++;
      if (o !== t[k]) begin
        errors++;
        $display("FAIL scoreboard dut%0d step%0d: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 k, step_no, o.x, o.y, o.hs, o.vs, o.de, o.ls, o.fs, o.fc,
                 t[k].x, t[k].y, t[k].hs, t[k].vs, t[k].de, t[k].ls, t[k].fs, t[k].fc);
      end
    end
    step_no++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k += 2) begin
      checks++;
      if ({ox[k], oy[k], ode[k], ohs[k], ovs[k], ols[k], ofs[k], ofc[k]} !== 53'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected all zero",
                 k, ox[k], oy[k], ode[k], ohs[k], ovs[k], ols[k], ofs[k], ofc[k]);
      end
    end
    checks++;
    if ({ohs[1], ovs[1]} !== 2'b11) begin
      errors++;
      $display("FAIL reset_pol_idle: got hs=%b vs=%b, expected 1 1", ohs[1], ovs[1]);
    end
  endtask

  task automatic test_small_frame();
    int fs_at [$];
    int fc_at [$];
    int last_ls = -1;
    int bad_ls = 0, bad_hs = 0, bad_de = 0, bad_vs = 0, bad_pol = 0;
    for (int n = 0; n < 200; n++) begin
      step(1'b1, 1'b1);
      if (n == 0) begin
        checks++;
        if ({ox[0], oy[0], ode[0], ols[0], ofs[0]} !== {16'd0, 16'd0, 3'b111}) begin
          errors++;
          $display("FAIL first_edge: got x=%0d y=%0d de=%b ls=%b fs=%b, expected 0 0 1 1 1",
                   ox[0], oy[0], ode[0], ols[0], ofs[0]);
        end
      end
      if (ofs[0]) begin fs_at.push_back(n); fc_at.push_back(int'(ofc[0])); end
      if (ols[0]) begin
        if (last_ls >= 0 && n - last_ls != 14) bad_ls++;
        last_ls = n;
      end
      if (ohs[0] !== (ox[0] >= 16'd10 && ox[0] <= 16'd11)) bad_hs++;
      if (ode[0] !== (ox[0] < 16'd8 && oy[0] < 16'd4)) bad_de++;
      if (ovs[0] !== (oy[0] == 16'd5)) bad_vs++;
      if (ohs[1] !== ~ohs[0] || ovs[1] !== ~ovs[0] || ox[1] !== ox[0] || oy[1] !== oy[0] ||
          ode[1] !== ode[0] || ols[1] !== ols[0] || ofs[1] !== ofs[0] || ofc[1] !== ofc[0])
        bad_pol++;
    end
    checks++;
    if (bad_ls != 0) begin errors++; $display("FAIL line_period: got %0d bad spacings, expected 0 (14 clocks)", bad_ls); end
    checks++;
    if (bad_hs != 0) begin errors++; $display("FAIL hsync_window: got %0d bad cycles, expected 0", bad_hs); end
    checks++;
    if (bad_de != 0) begin errors++; $display("FAIL de_window: got %0d bad cycles, expected 0", bad_de); end
    checks++;
    if (bad_vs != 0) begin errors++; $display("FAIL vsync_window: got %0d bad cycles, expected 0", bad_vs); end
    checks++;
    if (bad_pol != 0) begin errors++; $display("FAIL polarity: got %0d bad cycles, expected 0", bad_pol); end
    checks++;
    if (fs_at.size() < 2) begin
      errors++;
      $display("FAIL frame_period: got %0d frame_start pulses, expected at least 2", fs_at.size());
    end else if (fs_at[1] - fs_at[0] != 98 || fc_at[1] != 1) begin
      errors++;
      $display("FAIL frame_period: got period=%0d fc=%0d, expected period=98 fc=1",
               fs_at[1] - fs_at[0], fc_at[1]);
    end
  endtask

  task automatic test_default_line();
    int hs_x = -1;
    int hs_len = 0;
    int vs_hi = 0;
    int ls_second = -1;
    step(1'b0, 1'b1);
    for (int n = 0; n < 1700; n++) begin
      step(1'b1, 1'b1);
      if (n < 1650 && ohs[2]) begin
        if (hs_x < 0) hs_x = int'(ox[2]);
        hs_len++;
      end
      if (ovs[2]) vs_hi++;
      if (n > 0 && ols[2] && ls_second < 0) ls_second = n;
    end
    checks++;
    if (hs_x != 1390 || hs_len != 40) begin
      errors++;
      $display("FAIL default_hsync: got start x=%0d len=%0d, expected start x=1390 len=40", hs_x, hs_len);
    end
    checks++;
    if (vs_hi != 0) begin errors++; $display("FAIL default_vsync_idle: got %0d high cycles, expected 0", vs_hi); end
    checks++;
    if (ls_second != 1650) begin
      errors++;
      $display("FAIL default_line_period: got %0d, expected 1650", ls_second);
    end
  endtask

  task automatic test_ce_alternating();
    int fs_at [$];
    int doubled = 0;
    logic prev_fs = 1'b0, prev_ls = 1'b0;
    step(1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      step(1'b1, (n % 2 == 0) ? 1'b1 : 1'b0);
      if (ofs[0]) fs_at.push_back(n);
      if ((ofs[0] && prev_fs) || (ols[0] && prev_ls)) doubled++;
      prev_fs = ofs[0];
      prev_ls = ols[0];
    end
    checks++;
    if (doubled != 0) begin errors++; $display("FAIL strobe_width: got %0d doubled strobes, expected 0", doubled); end
    checks++;
    if (fs_at.size() < 2) begin
      errors++;
      $display("FAIL ce_frame_period: got %0d pulses, expected at least 2", fs_at.size());
    end else if (fs_at[1] - fs_at[0] != 196) begin
      errors++;
      $display("FAIL ce_frame_period: got %0d, expected 196", fs_at[1] - fs_at[0]);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    step(1'b0, 1'b1);
    for (int n = 0; n < 300 && !found; n++) begin
      step(1'b1, 1'b1);
      if (ofc[0] == 16'd1 && ox[0] == 16'd5 && oy[0] == 16'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach: got no position (5,2) in frame 1, expected one within 300 clocks");
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if ({ox[0], oy[0], ofs[0], ofc[0]} !== {16'd0, 16'd0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL mid_reset_restart: got x=%0d y=%0d fs=%b fc=%0d, expected 0 0 1 0",
               ox[0], oy[0], ofs[0], ofc[0]);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_small_frame();
    test_default_line();
    test_ce_alternating();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
